// File: rtl/wb_common_pkg.sv
// Shared Wishbone B3 codes and arbiter state encoding.
// Used by the round-robin master arbiter and its priority picker.
package wb_common_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OWN   = 2'd1,
    ARB_ABORT = 2'd2
  } arb_state_t;

  // Index width that stays at least one bit for a single master.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_rr_priority.sv
// Rotating-priority picker: first requester strictly after 'last', wrapping
// modulo N, returned both as a one-hot grant and as an index.
module wb_rr_priority
  import wb_common_pkg::*;
#(
  parameter int N  = 1,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);

  logic [IW-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    // k runs 1..N so that 'last' itself is considered only after everyone else.
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(last) + k) % N);
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/wb_rr_master_arbiter.sv
// N-to-1 Wishbone B3 round-robin arbiter with whole-cycle locking and a
// bus-hang watchdog that terminates a stalled access with ERR.
module wb_rr_master_arbiter
  import wb_common_pkg::*;
#(
  parameter int NUM_MASTERS    = 1,
  parameter int DW             = 32,
  parameter int AW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic [AW*NUM_MASTERS-1:0] wbm_adr_i,
  input  logic [DW*NUM_MASTERS-1:0] wbm_dat_i,
  input  logic [4*NUM_MASTERS-1:0]  wbm_sel_i,
  input  logic [NUM_MASTERS-1:0]    wbm_we_i,
  input  logic [NUM_MASTERS-1:0]    wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]    wbm_stb_i,
  input  logic [3*NUM_MASTERS-1:0]  wbm_cti_i,
  input  logic [2*NUM_MASTERS-1:0]  wbm_bte_i,
  output logic [DW-1:0]             wbm_dat_o,
  output logic [NUM_MASTERS-1:0]    wbm_ack_o,
  output logic [NUM_MASTERS-1:0]    wbm_err_o,
  output logic [NUM_MASTERS-1:0]    wbm_rty_o,
  output logic [AW-1:0]             wbs_adr_o,
  output logic [DW-1:0]             wbs_dat_o,
  output logic [3:0]                wbs_sel_o,
  output logic                      wbs_we_o,
  output logic                      wbs_cyc_o,
  output logic                      wbs_stb_o,
  output logic [2:0]                wbs_cti_o,
  output logic [1:0]                wbs_bte_o,
  input  logic [DW-1:0]             wbs_dat_i,
  input  logic                      wbs_ack_i,
  input  logic                      wbs_err_i,
  input  logic                      wbs_rty_i,
  output logic [NUM_MASTERS-1:0]    gnt_o
);

  localparam int          IW         = idx_width(NUM_MASTERS);
  localparam logic [15:0] TIMEOUT_16 = 16'(TIMEOUT_CYCLES);

  arb_state_t             state_reg;
  logic [IW-1:0]          owner_reg;
  logic [IW-1:0]          last_owner_reg;
  logic [NUM_MASTERS-1:0] gnt_reg;
  logic [15:0]            wd_reg;

  logic [IW-1:0]          pick_last;
  logic [IW-1:0]          pick_idx;
  logic [NUM_MASTERS-1:0] pick_gnt;
  logic                   pick_valid;
  logic                   own_cyc;
  logic                   own_stb;
  logic                   owning;
  logic                   slave_resp;

  // On release the departing owner becomes the rotation point immediately,
  // so the same edge can hand the bus to the next requester.
  assign pick_last = (state_reg == ARB_IDLE) ? last_owner_reg : owner_reg;

  wb_rr_priority #(
    .N  (NUM_MASTERS),
    .IW (IW)
  ) u_priority (
    .req   (wbm_cyc_i),
    .last  (pick_last),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign own_cyc    = wbm_cyc_i[owner_reg];
  assign own_stb    = wbm_stb_i[owner_reg];
  assign owning     = (state_reg == ARB_OWN);
  assign slave_resp = wbs_ack_i | wbs_err_i | wbs_rty_i;

  assign wbs_adr_o = wbm_adr_i[int'(owner_reg)*AW +: AW];
  assign wbs_dat_o = wbm_dat_i[int'(owner_reg)*DW +: DW];
  assign wbs_sel_o = wbm_sel_i[int'(owner_reg)*4 +: 4];
  assign wbs_cti_o = wbm_cti_i[int'(owner_reg)*3 +: 3];
  assign wbs_bte_o = wbm_bte_i[int'(owner_reg)*2 +: 2];
  assign wbs_we_o  = wbm_we_i[owner_reg];
  assign wbs_cyc_o = owning & own_cyc;
  assign wbs_stb_o = owning & own_cyc & own_stb;

  assign wbm_ack_o = {NUM_MASTERS{wbs_cyc_o & wbs_ack_i}} & gnt_reg;
  assign wbm_rty_o = {NUM_MASTERS{wbs_cyc_o & wbs_rty_i}} & gnt_reg;
  assign wbm_err_o = ({NUM_MASTERS{wbs_cyc_o & wbs_err_i}} |
                      {NUM_MASTERS{state_reg == ARB_ABORT}}) & gnt_reg;
  assign wbm_dat_o = (wbs_cyc_o & wbs_ack_i) ? wbs_dat_i : '0;
  assign gnt_o     = gnt_reg;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_reg      <= ARB_IDLE;
      owner_reg      <= '0;
      last_owner_reg <= IW'(NUM_MASTERS - 1);
      gnt_reg        <= '0;
      wd_reg         <= '0;
    end else if (state_reg == ARB_IDLE || !own_cyc) begin
      if (state_reg != ARB_IDLE) begin
        last_owner_reg <= owner_reg;
      end
      wd_reg <= '0;
      if (pick_valid) begin
        state_reg <= ARB_OWN;
        owner_reg <= pick_idx;
        gnt_reg   <= pick_gnt;
      end else begin
        state_reg <= ARB_IDLE;
        gnt_reg   <= '0;
      end
    end else if (state_reg == ARB_ABORT) begin
      state_reg <= ARB_OWN;
      wd_reg    <= '0;
    end else if (wbs_stb_o && !slave_resp) begin
      // A response in the final cycle takes the else path, so ack beats abort.
      if (TIMEOUT_CYCLES != 0 && (wd_reg + 16'd1) == TIMEOUT_16) begin
        state_reg <= ARB_ABORT;
        wd_reg    <= '0;
      end else begin
        wd_reg <= wd_reg + 16'd1;
      end
    end else begin
      wd_reg <= '0;
    end
  end

endmodule

// File: tb/tb_wb_rr_master_arbiter.sv
// Directed self-checking bench for wb_rr_master_arbiter: three masters,
// four-cycle watchdog, a simple slave that acks on demand.
module tb_wb_rr_master_arbiter;
  import wb_common_pkg::*;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [AW*N-1:0] wbm_adr;
  logic [DW*N-1:0] wbm_dat;
  logic [4*N-1:0]  wbm_sel;
  logic [N-1:0]    wbm_we, wbm_cyc, wbm_stb;
  logic [3*N-1:0]  wbm_cti;
  logic [2*N-1:0]  wbm_bte;
  logic [DW-1:0]   wbm_dat_o;
  logic [N-1:0]    wbm_ack, wbm_err, wbm_rty, gnt;
  logic [AW-1:0]   wbs_adr;
  logic [DW-1:0]   wbs_dat_o, wbs_dat_i;
  logic [3:0]      wbs_sel;
  logic            wbs_we, wbs_cyc, wbs_stb;
  logic [2:0]      wbs_cti;
  logic [1:0]      wbs_bte;
  logic            wbs_ack, wbs_err, wbs_rty;
  logic            ack_en, force_ack;

  int total = 0;
  int bad   = 0;

  // Slave: acks every strobe when enabled; read data tags the address.
  assign wbs_ack   = (ack_en & wbs_cyc & wbs_stb) | force_ack;
  assign wbs_dat_i = {8'hD0, wbs_adr[23:0]};
  assign wbs_err   = 1'b0;
  assign wbs_rty   = 1'b0;

  wb_rr_master_arbiter #(
    .NUM_MASTERS(N), .DW(DW), .AW(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbm_adr_i(wbm_adr), .wbm_dat_i(wbm_dat), .wbm_sel_i(wbm_sel),
    .wbm_we_i(wbm_we), .wbm_cyc_i(wbm_cyc), .wbm_stb_i(wbm_stb),
    .wbm_cti_i(wbm_cti), .wbm_bte_i(wbm_bte),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack), .wbm_err_o(wbm_err), .wbm_rty_o(wbm_rty),
    .wbs_adr_o(wbs_adr), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel), .wbs_we_o(wbs_we),
    .wbs_cyc_o(wbs_cyc), .wbs_stb_o(wbs_stb), .wbs_cti_o(wbs_cti), .wbs_bte_o(wbs_bte),
    .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack), .wbs_err_i(wbs_err), .wbs_rty_i(wbs_rty),
    .gnt_o(gnt)
  );

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    @(negedge clk);
  endtask

  task automatic set_m(input int i, input logic c, input logic s,
                       input logic [31:0] a, input logic [2:0] t);
    wbm_cyc[i] = c;
    wbm_stb[i] = s;
    wbm_adr[i*AW +: AW] = a;
    wbm_cti[i*3 +: 3] = t;
  endtask

  task automatic clear_inputs;
    wbm_adr = '0; wbm_dat = '0; wbm_sel = '0; wbm_we = '0;
    wbm_cyc = '0; wbm_stb = '0; wbm_cti = '0; wbm_bte = '0;
    ack_en = 1'b0; force_ack = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    clear_inputs();
    nxt(); nxt();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    clear_inputs();
    wbm_cyc = 3'b111; wbm_stb = 3'b111; ack_en = 1'b1;
    repeat (2) @(posedge clk);
    mid();
    total++; if (gnt !== 3'b000) begin bad++; $display("FAIL reset_gnt: got=%b want=000", gnt); end
    total++; if (wbs_cyc !== 1'b0 || wbs_stb !== 1'b0) begin bad++; $display("FAIL reset_cyc_stb: got=%b%b want=00", wbs_cyc, wbs_stb); end
    total++; if (wbm_ack !== 3'b000 || wbm_err !== 3'b000 || wbm_rty !== 3'b000) begin bad++; $display("FAIL reset_resp: ack=%b err=%b rty=%b want 000", wbm_ack, wbm_err, wbm_rty); end
    total++; if (wbm_dat_o !== 32'h0) begin bad++; $display("FAIL reset_dat: got=%h want=0", wbm_dat_o); end
    nxt();
    rst = 1'b0;
    clear_inputs();
    $display("test_reset checked");
  endtask

  task automatic test_first_grant;
    do_reset();
    set_m(0, 1'b1, 1'b1, 32'h0000_1000, CTI_CLASSIC);
    set_m(1, 1'b1, 1'b1, 32'h0000_2000, CTI_CLASSIC);
    wbm_we[0] = 1'b1; wbm_dat[31:0] = 32'h1111_2222; wbm_sel[3:0] = 4'hF;
    mid();
    total++; if (wbs_cyc !== 1'b0 || gnt !== 3'b000) begin bad++; $display("FAIL grant_latency: cyc=%b gnt=%b want 0/000", wbs_cyc, gnt); end
    nxt(); mid();
    total++; if (gnt !== 3'b001) begin bad++; $display("FAIL first_owner: got=%b want=001", gnt); end
    total++; if (wbs_cyc !== 1'b1 || wbs_adr !== 32'h0000_1000) begin bad++; $display("FAIL owner_mux_adr: cyc=%b adr=%h want 1/00001000", wbs_cyc, wbs_adr); end
    total++; if (wbs_we !== 1'b1 || wbs_dat_o !== 32'h1111_2222 || wbs_sel !== 4'hF) begin bad++; $display("FAIL owner_mux_wr: we=%b dat=%h sel=%h want 1/11112222/f", wbs_we, wbs_dat_o, wbs_sel); end
    nxt(); ack_en = 1'b1; mid();
    total++; if (wbm_ack !== 3'b001 || wbm_dat_o !== 32'hD000_1000) begin bad++; $display("FAIL m0_ack: ack=%b dat=%h want 001/d0001000", wbm_ack, wbm_dat_o); end
    nxt(); set_m(0, 1'b0, 1'b0, 32'h0, CTI_CLASSIC); mid();
    total++; if (wbs_cyc !== 1'b0 || wbm_ack !== 3'b000 || gnt !== 3'b001) begin bad++; $display("FAIL release_cycle: cyc=%b ack=%b gnt=%b want 0/000/001", wbs_cyc, wbm_ack, gnt); end
    nxt(); mid();
    total++; if (gnt !== 3'b010 || wbs_adr !== 32'h0000_2000 || wbm_ack !== 3'b010) begin bad++; $display("FAIL second_owner: gnt=%b adr=%h ack=%b want 010/00002000/010", gnt, wbs_adr, wbm_ack); end
    nxt(); set_m(1, 1'b0, 1'b0, 32'h0, CTI_CLASSIC); mid();
    nxt(); mid();
    total++; if (gnt !== 3'b000) begin bad++; $display("FAIL idle_after_release: got=%b want=000", gnt); end
    $display("test_first_grant checked");
  endtask

  task automatic test_round_robin;
    logic [2:0] exp_order [6];
    logic [2:0] drop;
    int n;
    exp_order = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    do_reset();
    ack_en = 1'b1;
    drop = 3'b000;
    n = 0;
    for (int c = 0; c < 40 && n < 6; c++) begin
      wbm_cyc = 3'b111 & ~drop;
      wbm_stb = 3'b111 & ~drop;
      mid();
      drop = wbm_ack;
      if (wbm_ack !== 3'b000) begin
        total++;
        if (wbm_ack !== exp_order[n]) begin bad++; $display("FAIL rr_order[%0d]: got=%b want=%b", n, wbm_ack, exp_order[n]); end
        n++;
      end
      nxt();
    end
    total++; if (n != 6) begin bad++; $display("FAIL rr_timeout: got=%0d acks want=6", n); end
    clear_inputs(); nxt();
    $display("test_round_robin checked");
  endtask

  task automatic test_burst;
    int beats;
    logic [2:0] want_cti;
    do_reset();
    ack_en = 1'b1;
    beats = 0;
    set_m(1, 1'b1, 1'b1, 32'h0000_3000, CTI_INC);
    mid(); nxt();
    set_m(0, 1'b1, 1'b1, 32'h0000_0100, CTI_CLASSIC);
    for (int c = 0; c < 20 && beats < 8; c++) begin
      want_cti = (beats == 7) ? CTI_EOB : CTI_INC;
      set_m(1, 1'b1, 1'b1, 32'h0000_3000 + 32'(4*beats), want_cti);
      mid();
      total++; if (gnt !== 3'b010 || wbm_ack[0] !== 1'b0) begin bad++; $display("FAIL burst_lock: gnt=%b ack=%b want 010, no m0 ack", gnt, wbm_ack); end
      if (wbm_ack[1]) begin
        total++; if (wbs_cti !== want_cti || wbm_dat_o !== 32'hD000_3000 + 32'(4*beats)) begin bad++; $display("FAIL burst_beat%0d: cti=%b dat=%h want %b/%h", beats, wbs_cti, wbm_dat_o, want_cti, 32'hD000_3000 + 32'(4*beats)); end
        beats++;
      end
      nxt();
    end
    total++; if (beats != 8) begin bad++; $display("FAIL burst_count: got=%0d want=8", beats); end
    set_m(1, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
    mid();
    total++; if (wbs_cyc !== 1'b0) begin bad++; $display("FAIL burst_release: cyc=%b want 0", wbs_cyc); end
    nxt(); mid();
    total++; if (gnt !== 3'b001 || wbm_ack !== 3'b001) begin bad++; $display("FAIL after_burst_m0: gnt=%b ack=%b want 001/001", gnt, wbm_ack); end
    clear_inputs(); nxt();
    $display("test_burst checked");
  endtask

  task automatic test_timeout;
    do_reset();
    set_m(2, 1'b1, 1'b1, 32'h0000_4000, CTI_CLASSIC);
    mid(); nxt();
    for (int c = 0; c < TO; c++) begin
      mid();
      total++; if (wbm_err !== 3'b000 || wbs_cyc !== 1'b1) begin bad++; $display("FAIL wd_wait%0d: err=%b cyc=%b want 000/1", c, wbm_err, wbs_cyc); end
      nxt();
    end
    mid();
    total++; if (wbm_err !== 3'b100) begin bad++; $display("FAIL wd_err: got=%b want=100", wbm_err); end
    total++; if (wbs_cyc !== 1'b0 || wbs_stb !== 1'b0) begin bad++; $display("FAIL wd_abort_bus: cyc=%b stb=%b want 0/0", wbs_cyc, wbs_stb); end
    nxt(); mid();
    total++; if (wbm_err !== 3'b000 || wbs_cyc !== 1'b1) begin bad++; $display("FAIL wd_err_once: err=%b cyc=%b want 000/1", wbm_err, wbs_cyc); end
    clear_inputs(); nxt();
    $display("test_timeout checked");
  endtask

  task automatic test_ack_race;
    do_reset();
    set_m(2, 1'b1, 1'b1, 32'h0000_5000, CTI_CLASSIC);
    mid(); nxt();
    for (int c = 0; c < TO - 1; c++) begin
      mid(); nxt();
    end
    force_ack = 1'b1;
    mid();
    total++; if (wbm_ack !== 3'b100 || wbm_err !== 3'b000 || wbm_dat_o !== 32'hD000_5000) begin bad++; $display("FAIL race_ack: ack=%b err=%b dat=%h want 100/000/d0005000", wbm_ack, wbm_err, wbm_dat_o); end
    nxt(); force_ack = 1'b0; mid();
    total++; if (wbm_err !== 3'b000 || wbs_cyc !== 1'b1) begin bad++; $display("FAIL race_no_abort: err=%b cyc=%b want 000/1", wbm_err, wbs_cyc); end
    clear_inputs(); nxt();
    $display("test_ack_race checked");
  endtask

  task automatic test_reset_mid_burst;
    do_reset();
    ack_en = 1'b1;
    set_m(1, 1'b1, 1'b1, 32'h0000_6000, CTI_INC);
    mid(); nxt();
    set_m(0, 1'b1, 1'b1, 32'h0000_7000, CTI_CLASSIC);
    set_m(2, 1'b1, 1'b1, 32'h0000_8000, CTI_CLASSIC);
    mid();
    total++; if (gnt !== 3'b010) begin bad++; $display("FAIL pre_reset_owner: got=%b want=010", gnt); end
    #1 rst = 1'b1;
    #1;
    total++; if (wbs_cyc !== 1'b0 || gnt !== 3'b000 || wbm_ack !== 3'b000) begin bad++; $display("FAIL async_reset: cyc=%b gnt=%b ack=%b want 0/000/000", wbs_cyc, gnt, wbm_ack); end
    nxt(); rst = 1'b0;
    mid();
    nxt(); mid();
    total++; if (gnt !== 3'b001 || wbs_adr !== 32'h0000_7000) begin bad++; $display("FAIL post_reset_priority: gnt=%b adr=%h want 001/00007000", gnt, wbs_adr); end
    clear_inputs(); nxt();
    $display("test_reset_mid_burst checked");
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_first_grant();
    test_round_robin();
    test_burst();
    test_timeout();
    test_ack_race();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_time_limit: got=expired want=finished");
    $fatal(1, "time limit");
  end

endmodule
